// File: rtl/block_ram_param.sv
// Simple dual-port block RAM: one byte-enabled write port, one read-first read port,
// optional output register. Define BRAM_CLEAR_EN to zero the array after every reset.
`ifndef LOG2
`define LOG2(x) $clog2(x)
`endif

module block_ram_param #(
    parameter int WIDTH   = 32,
    parameter int SIZE    = 256,
    parameter int OUT_REG = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_en,
    input  logic                      wr_en,
    input  logic [`LOG2(SIZE)-1:0]    wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [WIDTH/8-1:0]        wr_be,
    input  logic                      rd_en,
    input  logic [`LOG2(SIZE)-1:0]    rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic                      init_busy
);

    localparam int AW = `LOG2(SIZE);
    localparam int NB = WIDTH / 8;

    generate
        if ((WIDTH < 8) || ((WIDTH % 8) != 0)) begin : g_bad_width
            $error("block_ram_param: WIDTH must be a multiple of 8, at least 8");
        end
        if ((SIZE < 2) || ((SIZE & (SIZE - 1)) != 0)) begin : g_bad_size
            $error("block_ram_param: SIZE must be a power of two, at least 2");
        end
        if ((OUT_REG != 0) && (OUT_REG != 1)) begin : g_bad_outreg
            $error("block_ram_param: OUT_REG must be 0 or 1");
        end
    endgenerate

    logic [WIDTH-1:0] mem_q [SIZE];

    logic             busy;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [NB-1:0]    mem_be;
    logic             mem_wr;
    logic             rd_fire;

`ifdef BRAM_CLEAR_EN
    localparam logic [0:0] ST_READY = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == AW'(SIZE - 1)) begin
                state_d = ST_READY;
            end
        end
    end

    // Reset always restarts the sweep from address 0, whatever clk_en is doing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else if (clk_en) begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign busy = (state_q == ST_CLEAR);

    // While clearing, the sweep owns the write port and user requests are dropped.
    always_comb begin
        mem_we    = wr_en;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_be    = wr_be;
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
            mem_be    = '1;
        end
    end
`else
    assign busy = 1'b0;

    always_comb begin
        mem_we    = wr_en;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_be    = wr_be;
    end
`endif

    assign init_busy = busy;
    assign mem_wr    = clk_en & rst_n & mem_we;
    assign rd_fire   = rd_en & ~busy;

    // Write port: no reset on the array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Stage p0: array read register; nonblocking update gives read-first behaviour.
    logic [WIDTH-1:0] data_p0_q;
    logic             vld_p0_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_p0_q <= '0;
            vld_p0_q  <= 1'b0;
        end else if (clk_en) begin
            vld_p0_q <= rd_fire;
            if (rd_fire) begin
                data_p0_q <= mem_q[rd_addr];
            end
        end
    end

    // Stage p1: optional output register; data only advances with a valid result.
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] data_p1_q;
            logic             vld_p1_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_p1_q <= '0;
                    vld_p1_q  <= 1'b0;
                end else if (clk_en) begin
                    vld_p1_q <= vld_p0_q;
                    if (vld_p0_q) begin
                        data_p1_q <= data_p0_q;
                    end
                end
            end

            assign rd_data  = data_p1_q;
            assign rd_valid = vld_p1_q;
        end else begin : g_no_out_reg
            assign rd_data  = data_p0_q;
            assign rd_valid = vld_p0_q;
        end
    endgenerate

endmodule

// File: tb/tb_block_ram_param.sv
// Directed bench for block_ram_param: one instance without and one with the
// output register, driven from the same stimulus.
`timescale 1ns/1ps

module tb_block_ram_param;

    localparam int WIDTH = 32;
    localparam int SIZE  = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clk_en;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [3:0]       wr_be;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;

    logic [WIDTH-1:0] d0_data, d1_data;
    logic             d0_vld, d1_vld;
    logic             d0_busy, d1_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    block_ram_param #(.WIDTH(WIDTH), .SIZE(SIZE), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(d0_data), .rd_valid(d0_vld), .init_busy(d0_busy)
    );

    block_ram_param #(.WIDTH(WIDTH), .SIZE(SIZE), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(d1_data), .rd_valid(d1_vld), .init_busy(d1_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; clk_en = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
        tick(); tick();

        check("rst_d0_data", d0_data, 32'h0);
        check("rst_d0_vld",  {31'b0, d0_vld}, 32'h0);
        check("rst_d1_data", d1_data, 32'h0);
        check("rst_d1_vld",  {31'b0, d1_vld}, 32'h0);
`ifdef BRAM_CLEAR_EN
        check("rst_busy", {31'b0, d0_busy}, 32'h1);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("clr_busy_%0d", k), {31'b0, d0_busy}, (k < 16) ? 32'h1 : 32'h0);
        end
        // Interrupt a sweep at counter 8: it must restart and take 16 more cycles.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        rst_n = 1'b0; tick();
        check("clr_restart_busy", {31'b0, d1_busy}, 32'h1);
        rst_n = 1'b1; rd_en = 1'b1; rd_addr = 4'd3;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("clr2_busy_%0d", k), {31'b0, d1_busy}, (k < 16) ? 32'h1 : 32'h0);
            check($sformatf("clr2_novld_%0d", k), {31'b0, d0_vld}, 32'h0);
        end
        for (int i = 0; i < SIZE; i++) begin
            rd_addr = AW'(i);
            tick();
            check($sformatf("clr_rd_%0d", i), d0_data, 32'h0);
            check($sformatf("clr_vld_%0d", i), {31'b0, d0_vld}, 32'h1);
        end
        rd_en = 1'b0; tick();
`else
        check("rst_busy", {31'b0, d0_busy}, 32'h0);
        rst_n = 1'b1;
        tick();
`endif

        // Full-word write then read, latency 1 vs 2.
        write(4'd5, 32'hDEADBEEF, 4'hF);
        rd_en = 1'b1; rd_addr = 4'd5; tick(); rd_en = 1'b0;
        check("t1_d0_data", d0_data, 32'hDEADBEEF);
        check("t1_d0_vld",  {31'b0, d0_vld}, 32'h1);
        check("t1_d1_vld",  {31'b0, d1_vld}, 32'h0);
        tick();
        check("t1_d0_hold", d0_data, 32'hDEADBEEF);
        check("t1_d0_vld0", {31'b0, d0_vld}, 32'h0);
        check("t1_d1_data", d1_data, 32'hDEADBEEF);
        check("t1_d1_vld",  {31'b0, d1_vld}, 32'h1);
        tick();
        check("t1_d1_vld0", {31'b0, d1_vld}, 32'h0);

        // Partial byte write.
        write(4'd5, 32'h11223344, 4'b0101);
        rd_en = 1'b1; rd_addr = 4'd5; tick(); rd_en = 1'b0;
        check("t2_d0_data", d0_data, 32'hDE22BE44);
        tick();
        check("t2_d1_data", d1_data, 32'hDE22BE44);

        // Write with no bytes enabled leaves the word alone.
        write(4'd5, 32'hFFFFFFFF, 4'h0);
        rd_en = 1'b1; rd_addr = 4'd5; tick(); rd_en = 1'b0;
        check("t3_d0_data", d0_data, 32'hDE22BE44);
        tick();

        // Read-first on a same-address collision.
        write(4'd7, 32'h12345678, 4'hF);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hAAAA0000; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 4'd7;
        tick();
        wr_en = 1'b0;
        check("t4_d0_old", d0_data, 32'h12345678);
        tick(); rd_en = 1'b0;
        check("t4_d0_new", d0_data, 32'hAAAA0000);
        check("t4_d1_old", d1_data, 32'h12345678);
        tick();
        check("t4_d1_new", d1_data, 32'hAAAA0000);

        // Back-to-back reads.
        for (int i = 0; i < 3; i++) write(AW'(10 + i), 32'hC0DE0000 + i, 4'hF);
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1; rd_addr = AW'(10 + i);
            tick();
            check($sformatf("t5_d0_data_%0d", i), d0_data, 32'hC0DE0000 + i);
            check($sformatf("t5_d0_vld_%0d", i), {31'b0, d0_vld}, 32'h1);
            if (i > 0) begin
                check($sformatf("t5_d1_data_%0d", i), d1_data, 32'hC0DE0000 + i - 1);
                check($sformatf("t5_d1_vld_%0d", i), {31'b0, d1_vld}, 32'h1);
            end
        end

        // Stall with the last read still inside dut1; requests during the stall are ignored.
        clk_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd5;
        wr_en = 1'b1; wr_addr = 4'd11; wr_data = 32'hBAD0BAD0; wr_be = 4'hF;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t6_d0_data_%0d", k), d0_data, 32'hC0DE0002);
            check($sformatf("t6_d0_vld_%0d", k), {31'b0, d0_vld}, 32'h1);
            check($sformatf("t6_d1_data_%0d", k), d1_data, 32'hC0DE0001);
            check($sformatf("t6_d1_vld_%0d", k), {31'b0, d1_vld}, 32'h1);
        end
        clk_en = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        tick();
        check("t6_d0_vld_after", {31'b0, d0_vld}, 32'h0);
        check("t6_d1_data_after", d1_data, 32'hC0DE0002);
        check("t6_d1_vld_after", {31'b0, d1_vld}, 32'h1);
        tick();
        check("t6_d1_vld_end", {31'b0, d1_vld}, 32'h0);
        rd_en = 1'b1; rd_addr = 4'd11; tick(); rd_en = 1'b0;
        check("t6_nowrite", d0_data, 32'hC0DE0001);
        tick();

        // Reset with a result on the outputs and clk_en low.
        rd_en = 1'b1; rd_addr = 4'd5; tick(); rd_en = 1'b0;
        check("t7_pre_vld", {31'b0, d0_vld}, 32'h1);
        rst_n = 1'b0; clk_en = 1'b0;
        tick();
        check("t7_d0_data", d0_data, 32'h0);
        check("t7_d0_vld",  {31'b0, d0_vld}, 32'h0);
        check("t7_d1_data", d1_data, 32'h0);
        check("t7_d1_vld",  {31'b0, d1_vld}, 32'h0);
        rst_n = 1'b1; clk_en = 1'b1;
        tick();
        check("t7_d1_pipe_clr", {31'b0, d1_vld}, 32'h0);
        check("t7_d1_data_clr", d1_data, 32'h0);
`ifndef BRAM_CLEAR_EN
        rd_en = 1'b1; rd_addr = 4'd5; tick(); rd_en = 1'b0;
        check("t7_mem_kept", d0_data, 32'hDE22BE44);
        tick();
        check("t7_d1_mem_kept", d1_data, 32'hDE22BE44);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
